// File: rtl/obi_spi_master_arbiter_if.sv
// Single OBI channel bundle (address phase + response phase).
// "master" drives the address phase, "slave" grants it and returns responses.
interface obi_spi_master_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  req;
   logic                  gnt;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  we;
   logic [DATA_WIDTH-1:0] w_data;
   logic [3:0]            be;
   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_data;

   modport master (
      output req, addr, we, w_data, be,
      input  gnt, r_valid, r_data
   );

   modport slave (
      input  req, addr, we, w_data, be,
      output gnt, r_valid, r_data
   );
endinterface

// File: rtl/obi_spi_master_arbiter.sv
// Two-requester OBI arbiter with an ordered ID queue for response routing.
// Define OBI_SPI_ARB_RR_EN for round-robin; otherwise s0 has fixed priority.
module obi_spi_master_arbiter #(
   parameter int OBI_ADDR_WIDTH  = 32,
   parameter int OBI_DATA_WIDTH  = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                      obi_aclk,
   input  logic                      obi_aresetn,
   obi_spi_master_arbiter_if.slave   s0,
   obi_spi_master_arbiter_if.slave   s1,
   obi_spi_master_arbiter_if.master  obi_master,
   output logic                      arb_err
);

   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   logic                      sel;
   logic                      sel_q;
   logic                      locked_q;
   logic                      push;
   logic                      pop;
   logic                      full;
   logic                      head;
   logic                      req_mux;
   logic [OBI_ADDR_WIDTH-1:0] addr_mux;
   logic [OBI_DATA_WIDTH-1:0] w_data_mux;
   logic                      we_mux;
   logic [3:0]                be_mux;
   logic [MAX_OUTSTANDING-1:0] id_q;
   logic [PTR_W-1:0]          wr_ptr_q;
   logic [PTR_W-1:0]          rd_ptr_q;
   logic [CNT_W-1:0]          count_q;

`ifdef OBI_SPI_ARB_RR_EN
   logic last_q;
`endif

   // A stalled address phase keeps its owner until the handshake completes.
   always_comb begin
      sel = sel_q;
      if (!locked_q) begin
`ifdef OBI_SPI_ARB_RR_EN
         if (s0.req && s1.req) begin
            sel = ~last_q;
         end else begin
            sel = s1.req;
         end
`else
         sel = s1.req && !s0.req;
`endif
      end
   end

   always_comb begin
      req_mux    = s0.req;
      addr_mux   = s0.addr;
      we_mux     = s0.we;
      w_data_mux = s0.w_data;
      be_mux     = s0.be;
      if (sel) begin
         req_mux    = s1.req;
         addr_mux   = s1.addr;
         we_mux     = s1.we;
         w_data_mux = s1.w_data;
         be_mux     = s1.be;
      end
   end

   assign full              = (count_q == CNT_MAX);
   assign obi_master.req    = req_mux && !full;
   assign obi_master.addr   = addr_mux;
   assign obi_master.we     = we_mux;
   assign obi_master.w_data = w_data_mux;
   assign obi_master.be     = be_mux;

   assign push   = obi_master.req && obi_master.gnt;
   assign s0.gnt = push && !sel;
   assign s1.gnt = push && sel;

   // A response with nothing outstanding is flagged but never routed.
   assign head       = id_q[rd_ptr_q];
   assign pop        = obi_master.r_valid && (count_q != '0);
   assign arb_err    = obi_master.r_valid && (count_q == '0);
   assign s0.r_valid = pop && !head;
   assign s1.r_valid = pop && head;
   assign s0.r_data  = obi_master.r_data;
   assign s1.r_data  = obi_master.r_data;

   always_ff @(posedge obi_aclk or negedge obi_aresetn) begin
      if (!obi_aresetn) begin
         sel_q    <= 1'b0;
         locked_q <= 1'b0;
         id_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         sel_q    <= sel;
         locked_q <= obi_master.req && !obi_master.gnt;
         if (push) begin
            id_q[wr_ptr_q] <= sel;
            wr_ptr_q       <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef OBI_SPI_ARB_RR_EN
   // Reset value 1 lets s0 win the very first contended cycle.
   always_ff @(posedge obi_aclk or negedge obi_aresetn) begin
      if (!obi_aresetn) begin
         last_q <= 1'b1;
      end else if (push) begin
         last_q <= sel;
      end
   end
`endif

endmodule

// File: tb/tb_obi_spi_master_arbiter.sv
// Directed self-checking bench for obi_spi_master_arbiter.
// Expected grant order follows OBI_SPI_ARB_RR_EN when it is defined.
module tb_obi_spi_master_arbiter;

   logic obi_aclk;
   logic obi_aresetn;
   int   checkCount;
   int   errorCount;

   obi_spi_master_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s0Bus ();
   obi_spi_master_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s1Bus ();
   obi_spi_master_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mBus ();
   logic arbErr;

   obi_spi_master_arbiter #(
      .OBI_ADDR_WIDTH (32),
      .OBI_DATA_WIDTH (32),
      .MAX_OUTSTANDING(4)
   ) dut (
      .obi_aclk   (obi_aclk),
      .obi_aresetn(obi_aresetn),
      .s0         (s0Bus),
      .s1         (s1Bus),
      .obi_master (mBus),
      .arb_err    (arbErr)
   );

   initial obi_aclk = 1'b0;
   always #5 obi_aclk = ~obi_aclk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives every bench-owned input, then settles before checks.
   task automatic applyStimulus(input logic r0, input logic [31:0] a0,
                                input logic r1, input logic [31:0] a1,
                                input logic gnt, input logic rv,
                                input logic [31:0] rd);
      s0Bus.req     = r0;
      s0Bus.addr    = a0;
      s0Bus.we      = 1'b1;
      s0Bus.w_data  = 32'hDEADBEEF;
      s0Bus.be      = 4'hF;
      s1Bus.req     = r1;
      s1Bus.addr    = a1;
      s1Bus.we      = 1'b0;
      s1Bus.w_data  = 32'h11111111;
      s1Bus.be      = 4'h3;
      mBus.gnt      = gnt;
      mBus.r_valid  = rv;
      mBus.r_data   = rd;
      #1;
   endtask

   task automatic tick();
      @(posedge obi_aclk);
      #1;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_mreq"}, 64'(mBus.req), 64'd0);
      checkOutput({tag, "_gnt"}, 64'({s0Bus.gnt, s1Bus.gnt}), 64'd0);
      checkOutput({tag, "_rvalid"}, 64'({s0Bus.r_valid, s1Bus.r_valid}), 64'd0);
      checkOutput({tag, "_err"}, 64'(arbErr), 64'd0);
   endtask

   task automatic resetDut();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      obi_aresetn = 1'b0;
      #1;
      checkIdle("reset");
      tick();
      tick();
      obi_aresetn = 1'b1;
      #1;
   endtask

   logic expSel [4];
   logic [31:0] rspData;

   initial begin
      checkCount  = 0;
      errorCount  = 0;
      obi_aresetn = 1'b0;

      // Single s0 write, then its response one cycle later.
      resetDut();
      applyStimulus(1'b1, 32'h1000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("wr_mreq", 64'(mBus.req), 64'd1);
      checkOutput("wr_addr", 64'(mBus.addr), 64'h1000);
      checkOutput("wr_we", 64'(mBus.we), 64'd1);
      checkOutput("wr_wdata", 64'(mBus.w_data), 64'hDEADBEEF);
      checkOutput("wr_be", 64'(mBus.be), 64'hF);
      checkOutput("wr_gnt", 64'({s0Bus.gnt, s1Bus.gnt}), 64'b10);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE);
      checkOutput("wr_rvalid", 64'({s0Bus.r_valid, s1Bus.r_valid}), 64'b10);
      checkOutput("wr_rdata0", 64'(s0Bus.r_data), 64'hCAFE);
      checkOutput("wr_rdata1", 64'(s1Bus.r_data), 64'hCAFE);
      checkOutput("wr_err", 64'(arbErr), 64'd0);
      tick();

      // Both requesters contend every cycle.
      resetDut();
`ifdef OBI_SPI_ARB_RR_EN
      expSel = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      expSel = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
         checkOutput($sformatf("both_gnt%0d", i), 64'({s0Bus.gnt, s1Bus.gnt}),
                     expSel[i] ? 64'b01 : 64'b10);
         tick();
      end

      // Stalled s1 address phase must not be stolen by a late s0 request.
      resetDut();
      applyStimulus(1'b0, 32'h3000, 1'b1, 32'h2000, 1'b0, 1'b0, 32'h0);
      checkOutput("lock_addr1", 64'(mBus.addr), 64'h2000);
      tick();
      for (int i = 2; i <= 3; i++) begin
         applyStimulus(1'b1, 32'h3000, 1'b1, 32'h2000, 1'b0, 1'b0, 32'h0);
         checkOutput($sformatf("lock_addr%0d", i), 64'(mBus.addr), 64'h2000);
         checkOutput($sformatf("lock_gnt%0d", i), 64'({s0Bus.gnt, s1Bus.gnt}), 64'b00);
         tick();
      end
      applyStimulus(1'b1, 32'h3000, 1'b1, 32'h2000, 1'b1, 1'b0, 32'h0);
      checkOutput("lock_gnt4", 64'({s0Bus.gnt, s1Bus.gnt}), 64'b01);
      checkOutput("lock_we4", 64'({mBus.we, mBus.be}), 64'b0_0011);
      tick();
      applyStimulus(1'b1, 32'h3000, 1'b0, 32'h2000, 1'b1, 1'b0, 32'h0);
      checkOutput("lock_gnt5", 64'({s0Bus.gnt, s1Bus.gnt}), 64'b10);
      checkOutput("lock_addr5", 64'(mBus.addr), 64'h3000);
      tick();

      // Outstanding limit: fifth request stalls until a response retires one.
      resetDut();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
         checkOutput($sformatf("full_gnt%0d", i), 64'(s0Bus.gnt), 64'd1);
         tick();
      end
      applyStimulus(1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("full_mreq", 64'(mBus.req), 64'd0);
      checkOutput("full_gnt", 64'(s0Bus.gnt), 64'd0);
      tick();
      applyStimulus(1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 1'b1, 32'h55);
      checkOutput("full_pop_mreq", 64'(mBus.req), 64'd0);
      checkOutput("full_pop_rvalid", 64'(s0Bus.r_valid), 64'd1);
      tick();
      applyStimulus(1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("full_resume_gnt", 64'(s0Bus.gnt), 64'd1);
      tick();

      // Interleaved owners are returned in order.
      resetDut();
      expSel = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(!expSel[i], 32'h500, expSel[i], 32'h600, 1'b1, 1'b0, 32'h0);
         tick();
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         rspData = 32'(i + 1);
         applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, rspData);
         checkOutput($sformatf("route_rv%0d", i), 64'({s0Bus.r_valid, s1Bus.r_valid}),
                     expSel[i] ? 64'b01 : 64'b10);
         checkOutput($sformatf("route_data%0d", i),
                     64'(expSel[i] ? s1Bus.r_data : s0Bus.r_data), 64'(i + 1));
         tick();
      end

      // Stray response with nothing outstanding; counter must not underflow.
      resetDut();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h77);
      checkOutput("err_pulse", 64'(arbErr), 64'd1);
      checkOutput("err_rvalid", 64'({s0Bus.r_valid, s1Bus.r_valid}), 64'd0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("err_clear", 64'(arbErr), 64'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b1, 32'h800, 1'b1, 1'b0, 32'h0);
         tick();
      end
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h800, 1'b1, 1'b0, 32'h0);
      checkOutput("err_cnt_full", 64'(mBus.req), 64'd0);

      // Reset with three transactions outstanding drops them all.
      resetDut();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h900, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
         tick();
      end
      resetDut();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h99);
      checkOutput("rst_drop_err", 64'(arbErr), 64'd1);
      checkOutput("rst_drop_rvalid", 64'({s0Bus.r_valid, s1Bus.r_valid}), 64'd0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
